// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle used between the packet generator and its downstream sink.
interface axis_pkt_gen_if #(
  parameter int DATA_W = 32
) ();
  logic                  tvalid;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tkeep;
  logic                  tlast;
  logic                  tready;

  modport master (output tvalid, tdata, tkeep, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet generator: fixed packet count, (p + n) mod 256 byte pattern, optional gap.
// Define AXIS_PKT_GEN_THROTTLE_EN to add LFSR-driven TVALID throttling (timing only).
module axis_pkt_gen #(
  parameter int C_TDATA_WIDTH   = 32,
  parameter int C_NUM_PKTS      = 4,
  parameter int C_PKT_LEN_BYTES = 64,
  parameter int C_LEN_STEP      = 0,
  parameter int C_IPG_CYCLES    = 4
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             START,
  axis_pkt_gen_if.master   m_axis,
  output logic             LAST_PKT,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      PKT_CNT
);

  localparam int     B        = C_TDATA_WIDTH / 8;
  localparam longint LAST_LEN = longint'(C_PKT_LEN_BYTES)
                              + longint'(C_NUM_PKTS - 1) * longint'(C_LEN_STEP);
  localparam int     GAP_W    = (C_IPG_CYCLES > 0) ? $clog2(C_IPG_CYCLES + 1) : 1;

  if (C_TDATA_WIDTH % 8 != 0 || C_TDATA_WIDTH < 8 || C_TDATA_WIDTH > 512) begin : g_bad_width
    $error("axis_pkt_gen: C_TDATA_WIDTH must be a multiple of 8 in 8..512");
  end
  if (C_NUM_PKTS < 1 || C_NUM_PKTS > 65535 || C_PKT_LEN_BYTES < 1 || C_LEN_STEP < 0
      || C_IPG_CYCLES < 0) begin : g_bad_cfg
    $error("axis_pkt_gen: illegal packet count, length, step or gap");
  end
  if (LAST_LEN > 65535) begin : g_bad_len
    $error("axis_pkt_gen: length of the final packet exceeds 65535 bytes");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [15:0]        offset_q;    // byte offset of the current beat's lane 0
  logic [15:0]        len_q;       // length of the current packet
  logic [15:0]        pkt_cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic               last_pkt_q;
  logic               tvalid_c;
  logic               last_beat;
  logic               final_pkt;
  logic               hs;

  assign last_beat = (int'(offset_q) + B) >= int'(len_q);
  assign final_pkt = (pkt_cnt_q == 16'(C_NUM_PKTS - 1));
  assign hs        = tvalid_c && m_axis.tready;

`ifdef AXIS_PKT_GEN_THROTTLE_EN
  // gate_q holds back a beat only while TVALID is already low, so a raised
  // TVALID always survives until its handshake.
  logic [15:0] lfsr_q;
  logic        gate_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      lfsr_q <= 16'hACE1;
      gate_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      gate_q <= !tvalid_c && lfsr_q[0];
    end
  end

  assign tvalid_c = (state_q == S_SEND) && !gate_q;
`else
  assign tvalid_c = (state_q == S_SEND);
`endif

  // NOTE: ARESETN is sampled only on the ACLK edge (synchronous reset), and all
  // state here is updated with non-blocking assignments so every register sees
  // pre-edge values of its neighbours.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the default assignment at the top of each always_comb prevents latches
  // on paths that do not assign every signal.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (START) state_d = S_SEND;
      S_SEND: begin
        if (hs && last_beat) begin
          if (final_pkt)              state_d = S_DONE;
          else if (C_IPG_CYCLES == 0) state_d = S_SEND;
          else                        state_d = S_GAP;
        end
      end
      S_GAP: if (gap_q == '0) state_d = S_SEND;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      offset_q   <= '0;
      len_q      <= '0;
      pkt_cnt_q  <= '0;
      gap_q      <= '0;
      last_pkt_q <= 1'b0;
    end else begin
      last_pkt_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (START) begin
            offset_q  <= '0;
            len_q     <= 16'(C_PKT_LEN_BYTES);
            pkt_cnt_q <= '0;
          end
        end
        S_SEND: begin
          if (hs) begin
            if (last_beat) begin
              offset_q   <= '0;
              len_q      <= len_q + 16'(C_LEN_STEP);
              pkt_cnt_q  <= pkt_cnt_q + 16'd1;
              gap_q      <= GAP_W'(C_IPG_CYCLES - 1);
              last_pkt_q <= final_pkt;
            end else begin
              offset_q <= offset_q + 16'(B);
            end
          end
        end
        S_GAP:   gap_q <= gap_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Beat contents are a pure function of registered state, so they cannot
  // change while a presented beat waits for TREADY.
  always_comb begin
    logic [C_TDATA_WIDTH-1:0] data_c;
    logic [B-1:0]             keep_c;
    int                       lane_off;
    data_c   = '0;
    keep_c   = '0;
    lane_off = 0;
    if (state_q == S_SEND) begin
      for (int i = 0; i < B; i++) begin
        lane_off = int'(offset_q) + i;
        if (lane_off < int'(len_q)) begin
          keep_c[i]        = 1'b1;
          data_c[8*i +: 8] = 8'(int'(pkt_cnt_q) + lane_off);
        end
      end
    end
    m_axis.tvalid = tvalid_c;
    m_axis.tdata  = data_c;
    m_axis.tkeep  = keep_c;
    m_axis.tlast  = (state_q == S_SEND) && last_beat;
    LAST_PKT      = last_pkt_q;
    BUSY          = (state_q == S_SEND) || (state_q == S_GAP);
    DONE          = (state_q == S_DONE);
    PKT_CNT       = pkt_cnt_q;
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Scoreboard bench for axis_pkt_gen: three parameter sets, backpressure and mid-packet reset.
module tb_axis_pkt_gen;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic start_a, start_b, start_c;
  logic last_a, last_b, last_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic rdy_a, bp_en, gap_en;
  logic [5:0] bp_pat = 6'b101001;   // TREADY sequence 1,0,0,1,0,1 read from bit 0
  int   bp_idx = 0;

  int n_cmp = 0;
  int n_bad = 0;
  beat_t q_a[$];
  beat_t q_b[$];
  beat_t q_c[$];
  int beats_a = 0, beats_b = 0, beats_c = 0;
  int lp_a = 0, lp_b = 0, lp_c = 0;
  int stalls = 0;

  always #5 ACLK = ~ACLK;

  axis_pkt_gen_if #(.DATA_W(32)) if_a ();
  axis_pkt_gen_if #(.DATA_W(32)) if_b ();
  axis_pkt_gen_if #(.DATA_W(32)) if_c ();

  assign if_a.tready = bp_en ? bp_pat[bp_idx] : rdy_a;
  assign if_b.tready = 1'b1;
  assign if_c.tready = 1'b1;

  always @(posedge ACLK) bp_idx <= (bp_idx == 5) ? 0 : bp_idx + 1;

  axis_pkt_gen dut_a (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(start_a), .m_axis(if_a),
    .LAST_PKT(last_a), .BUSY(busy_a), .DONE(done_a), .PKT_CNT(cnt_a)
  );

  axis_pkt_gen #(.C_PKT_LEN_BYTES(13), .C_NUM_PKTS(1)) dut_b (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(start_b), .m_axis(if_b),
    .LAST_PKT(last_b), .BUSY(busy_b), .DONE(done_b), .PKT_CNT(cnt_b)
  );

  axis_pkt_gen #(.C_PKT_LEN_BYTES(4), .C_LEN_STEP(3), .C_NUM_PKTS(3)) dut_c (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(start_c), .m_axis(if_c),
    .LAST_PKT(last_c), .BUSY(busy_c), .DONE(done_c), .PKT_CNT(cnt_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected beats of a whole run, 4-byte lanes, little-endian.
  task automatic push_run(input int id, input int len0, input int step, input int npkts);
    beat_t b;
    int    len, nb, n;
    for (int p = 0; p < npkts; p++) begin
      len = len0 + p * step;
      nb  = (len + 3) / 4;
      for (int bt = 0; bt < nb; bt++) begin
        b = '0;
        for (int i = 0; i < 4; i++) begin
          n = bt * 4 + i;
          if (n < len) begin
            b.keep[i]        = 1'b1;
            b.data[8*i +: 8] = 8'((p + n) % 256);
          end
        end
        b.last = (bt == nb - 1);
        case (id)
          0:       q_a.push_back(b);
          1:       q_b.push_back(b);
          default: q_c.push_back(b);
        endcase
      end
    end
  endtask

  task automatic sb_pop(input int id, input logic [36:0] got);
    beat_t e;
    int    sz;
    case (id)
      0:       sz = q_a.size();
      1:       sz = q_b.size();
      default: sz = q_c.size();
    endcase
    if (sz == 0) begin
      check($sformatf("sb%0d_extra_beat", id), 64'd1, 64'd0);
      return;
    end
    case (id)
      0:       e = q_a.pop_front();
      1:       e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
    check($sformatf("sb%0d_beat", id), 64'(got), 64'(e));
  endtask

  always @(negedge ACLK) begin
    if (ARESETN && if_a.tvalid && if_a.tready) begin
      sb_pop(0, {if_a.tdata, if_a.tkeep, if_a.tlast});
      beats_a <= beats_a + 1;
    end
    if (ARESETN && if_b.tvalid && if_b.tready) begin
      sb_pop(1, {if_b.tdata, if_b.tkeep, if_b.tlast});
      beats_b <= beats_b + 1;
    end
    if (ARESETN && if_c.tvalid && if_c.tready) begin
      sb_pop(2, {if_c.tdata, if_c.tkeep, if_c.tlast});
      beats_c <= beats_c + 1;
    end
    if (last_a) begin lp_a <= lp_a + 1; check("a_lastpkt_with_done", 64'(done_a), 64'd1); end
    if (last_b) lp_b <= lp_b + 1;
    if (last_c) lp_c <= lp_c + 1;
  end

  // Stability of a stalled beat on dut_a.
  logic        stalled = 1'b0;
  logic [36:0] held    = '0;
  always @(negedge ACLK) begin
    if (stalled && ARESETN) begin
      check("stall_tvalid_held", 64'(if_a.tvalid), 64'd1);
      check("stall_payload_held", 64'({if_a.tdata, if_a.tkeep, if_a.tlast}), 64'(held));
    end
    stalled <= ARESETN && if_a.tvalid && !if_a.tready;
    held    <= {if_a.tdata, if_a.tkeep, if_a.tlast};
    if (ARESETN && if_a.tvalid && !if_a.tready) stalls <= stalls + 1;
  end

  // Inter-packet gap length on dut_a (TVALID low while still BUSY).
  int   gap_len = 0;
  logic in_gap  = 1'b0;
  always @(negedge ACLK) begin
    if (gap_en && ARESETN) begin
      if (if_a.tvalid) begin
`ifndef AXIS_PKT_GEN_THROTTLE_EN
        if (in_gap) check("ipg_cycles", 64'(gap_len), 64'd4);
`endif
        in_gap  <= 1'b0;
        gap_len <= 0;
      end else if (busy_a) begin
        in_gap  <= 1'b1;
        gap_len <= gap_len + 1;
      end
    end
  end

  task automatic pulse_start(input logic a, input logic b, input logic c);
    @(posedge ACLK); #1;
    start_a = a; start_b = b; start_c = c;
    @(posedge ACLK); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit all3);
    int cyc;
    cyc = 0;
    while (cyc < 3000 && !(done_a && (!all3 || (done_b && done_c)))) begin
      @(negedge ACLK);
      cyc++;
    end
    check(tag, 64'(cyc < 3000), 64'd1);
  endtask

  initial begin
    int  ba, bb, bc, la, lb, lc;
    bit  found;
    ARESETN = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rdy_a   = 1'b1; bp_en = 1'b0; gap_en = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_tvalid",   64'(if_a.tvalid), 64'd0);
    check("rst_tdata",    64'(if_a.tdata),  64'd0);
    check("rst_tkeep",    64'(if_a.tkeep),  64'd0);
    check("rst_tlast",    64'(if_a.tlast),  64'd0);
    check("rst_last_pkt", 64'(last_a),      64'd0);
    check("rst_busy",     64'(busy_a),      64'd0);
    check("rst_done",     64'(done_a),      64'd0);
    check("rst_pkt_cnt",  64'(cnt_a),       64'd0);
    check("rst_b_c_tvalid", 64'({if_b.tvalid, if_c.tvalid}), 64'd0);
    ARESETN = 1'b1;

    // Run 1: all three configurations, no backpressure.
    gap_en = 1'b1;
    push_run(0, 64, 0, 4);
    push_run(1, 13, 0, 1);
    push_run(2, 4, 3, 3);
    ba = beats_a; bb = beats_b; bc = beats_c; la = lp_a; lb = lp_b; lc = lp_c;
    pulse_start(1'b1, 1'b1, 1'b1);
    check("run1_busy", 64'(busy_a), 64'd1);
    wait_done("run1_timeout", 1'b1);
    repeat (3) @(negedge ACLK);
    check("run1_a_drained", 64'(q_a.size()), 64'd0);
    check("run1_b_drained", 64'(q_b.size()), 64'd0);
    check("run1_c_drained", 64'(q_c.size()), 64'd0);
    check("run1_a_beats",   64'(beats_a - ba), 64'd64);
    check("run1_b_beats",   64'(beats_b - bb), 64'd4);
    check("run1_c_beats",   64'(beats_c - bc), 64'd6);
    check("run1_a_lastpkt", 64'(lp_a - la), 64'd1);
    check("run1_b_lastpkt", 64'(lp_b - lb), 64'd1);
    check("run1_c_lastpkt", 64'(lp_c - lc), 64'd1);
    check("run1_a_pkt_cnt", 64'(cnt_a), 64'd4);
    check("run1_b_pkt_cnt", 64'(cnt_b), 64'd1);
    check("run1_c_pkt_cnt", 64'(cnt_c), 64'd3);
    check("run1_a_done_busy", 64'({done_a, busy_a, last_a}), 64'b100);

    // Run 2: dut_a restarted from DONE under backpressure.
    bp_en = 1'b1;
    push_run(0, 64, 0, 4);
    ba = beats_a; la = lp_a;
    pulse_start(1'b1, 1'b0, 1'b0);
    wait_done("run2_timeout", 1'b0);
    repeat (3) @(negedge ACLK);
    check("run2_drained",   64'(q_a.size()), 64'd0);
    check("run2_beats",     64'(beats_a - ba), 64'd64);
    check("run2_lastpkt",   64'(lp_a - la), 64'd1);
    check("run2_pkt_cnt",   64'(cnt_a), 64'd4);
    check("run2_saw_stall", 64'(stalls > 0), 64'd1);
    bp_en  = 1'b0;
    gap_en = 1'b0;

    // Run 3: reset while packet 1 beat 5 is presented, then a clean restart.
    push_run(0, 64, 0, 4);
    pulse_start(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int cyc = 0; cyc < 400 && !found; cyc++) begin
      @(negedge ACLK);
      if (if_a.tvalid && cnt_a == 16'd1 && if_a.tdata == 32'h18171615) found = 1'b1;
    end
    check("rst_mid_found_beat", 64'(found), 64'd1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    q_a.delete();
    check("rst_mid_tvalid",  64'(if_a.tvalid), 64'd0);
    check("rst_mid_pkt_cnt", 64'(cnt_a), 64'd0);
    check("rst_mid_busy",    64'(busy_a), 64'd0);
    ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    check("rst_mid_no_resume", 64'({if_a.tvalid, busy_a}), 64'd0);
    push_run(0, 64, 0, 4);
    ba = beats_a;
    pulse_start(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      @(negedge ACLK);
      if (if_a.tvalid) found = 1'b1;
    end
    check("restart_tvalid",     64'(found), 64'd1);
    check("restart_first_data", 64'(if_a.tdata), 64'h03020100);
    wait_done("run3_timeout", 1'b0);
    repeat (3) @(negedge ACLK);
    check("run3_drained", 64'(q_a.size()), 64'd0);
    check("run3_beats",   64'(beats_a - ba), 64'd64);
    check("run3_pkt_cnt", 64'(cnt_a), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
